// File: rtl/axi4_mem_port_arbiter_if.sv
// Client-side and memory-side AXI4 subset seen by the memory port arbiter.
// Client vectors are flattened: client i owns slice i of each field.
interface axi4_mem_port_arbiter_if #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512
);
    localparam int STRB_W = DATA_WIDTH / 8;

    logic [NUM_CH-1:0]            s_arvalid, s_arready;
    logic [NUM_CH*ADDR_WIDTH-1:0] s_araddr;
    logic [NUM_CH*8-1:0]          s_arlen;
    logic [NUM_CH-1:0]            s_rvalid, s_rlast, s_rready;
    logic [DATA_WIDTH-1:0]        s_rdata;
    logic [NUM_CH-1:0]            s_awvalid, s_awready;
    logic [NUM_CH*ADDR_WIDTH-1:0] s_awaddr;
    logic [NUM_CH*8-1:0]          s_awlen;
    logic [NUM_CH-1:0]            s_wvalid, s_wlast, s_wready;
    logic [NUM_CH*DATA_WIDTH-1:0] s_wdata;
    logic [NUM_CH*STRB_W-1:0]     s_wstrb;
    logic [NUM_CH-1:0]            s_bvalid, s_bready;

    logic                  m_axi_arvalid, m_axi_arready;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic                  m_axi_rvalid, m_axi_rlast, m_axi_rready;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic                  m_axi_awvalid, m_axi_awready;
    logic [ADDR_WIDTH-1:0] m_axi_awaddr;
    logic [7:0]            m_axi_awlen;
    logic                  m_axi_wvalid, m_axi_wlast, m_axi_wready;
    logic [DATA_WIDTH-1:0] m_axi_wdata;
    logic [STRB_W-1:0]     m_axi_wstrb;
    logic                  m_axi_bvalid, m_axi_bready;

    // Arbiter view
    modport slave (
        input  s_arvalid, s_araddr, s_arlen, s_rready,
        input  s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wlast, s_wdata, s_wstrb, s_bready,
        output s_arready, s_rvalid, s_rlast, s_rdata, s_awready, s_wready, s_bvalid,
        output m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
        output m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
        output m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready,
        input  m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        input  m_axi_awready, m_axi_wready, m_axi_bvalid
    );

    // Environment view (clients plus memory)
    modport master (
        output s_arvalid, s_araddr, s_arlen, s_rready,
        output s_awvalid, s_awaddr, s_awlen, s_wvalid, s_wlast, s_wdata, s_wstrb, s_bready,
        input  s_arready, s_rvalid, s_rlast, s_rdata, s_awready, s_wready, s_bvalid,
        input  m_axi_arvalid, m_axi_araddr, m_axi_arlen, m_axi_rready,
        input  m_axi_awvalid, m_axi_awaddr, m_axi_awlen,
        input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready,
        output m_axi_arready, m_axi_rvalid, m_axi_rdata, m_axi_rlast,
        output m_axi_awready, m_axi_wready, m_axi_bvalid
    );
endinterface

// File: rtl/axi4_mem_port_arbiter.sv
// N-client AXI4 arbiter onto one memory port: independent round-robin read and
// write paths, one outstanding burst each, sticky client wlast/awlen mismatch flag.
module axi4_mem_port_arbiter #(
    parameter int NUM_CH     = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    axi4_mem_port_arbiter_if.slave        bus,
    output logic                          rd_busy,
    output logic                          wr_busy,
    output logic                          wlast_err
);
    localparam int CH_W   = $clog2(NUM_CH);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

    // Returns {found, index} of the first requester at or after ptr.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   ptr);
        logic            found;
        logic [CH_W-1:0] win;
        int              idx;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
        return {found, win};
    endfunction

    function automatic logic [CH_W-1:0] rr_next(input logic [CH_W-1:0] g);
        return (int'(g) == NUM_CH - 1) ? '0 : g + CH_W'(1);
    endfunction

    r_state_t              r_st;
    logic [CH_W-1:0]       rd_ptr, rd_g, r_win;
    logic                  r_found;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]            ar_len_q;
    logic                  ar_vld;

    w_state_t              w_st;
    logic [CH_W-1:0]       wr_ptr, wr_g, w_win;
    logic                  w_found;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [7:0]            aw_len_q, w_cnt;
    logic                  aw_vld, w_beat, w_last_beat, b_hs, r_done;

    assign {r_found, r_win} = rr_pick(bus.s_arvalid, rd_ptr);
    assign {w_found, w_win} = rr_pick(bus.s_awvalid, wr_ptr);

    assign bus.m_axi_arvalid = ar_vld;
    assign bus.m_axi_araddr  = ar_addr_q;
    assign bus.m_axi_arlen   = ar_len_q;
    assign bus.s_rdata       = bus.m_axi_rdata;
    assign r_done = (r_st == R_DATA) && bus.m_axi_rvalid && bus.m_axi_rready && bus.m_axi_rlast;

    always_comb begin
        bus.s_arready    = '0;
        bus.s_rvalid     = '0;
        bus.s_rlast      = '0;
        bus.m_axi_rready = 1'b0;
        // Grant is combinational; gate with reset so nothing is accepted while held.
        if (r_st == R_IDLE && r_found && ap_rst_n) bus.s_arready[r_win] = 1'b1;
        if (r_st == R_DATA) begin
            bus.s_rvalid[rd_g] = bus.m_axi_rvalid;
            bus.s_rlast[rd_g]  = bus.m_axi_rlast;
            bus.m_axi_rready   = bus.s_rready[rd_g];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_st      <= R_IDLE;
            rd_ptr    <= '0;
            rd_g      <= '0;
            ar_addr_q <= '0;
            ar_len_q  <= '0;
            ar_vld    <= 1'b0;
            rd_busy   <= 1'b0;
        end else begin
            case (r_st)
                R_IDLE: if (r_found) begin
                    rd_g      <= r_win;
                    ar_addr_q <= bus.s_araddr[int'(r_win)*ADDR_WIDTH +: ADDR_WIDTH];
                    ar_len_q  <= bus.s_arlen[int'(r_win)*8 +: 8];
                    ar_vld    <= 1'b1;
                    rd_busy   <= 1'b1;
                    r_st      <= R_ADDR;
                end
                R_ADDR: if (bus.m_axi_arready) begin
                    ar_vld <= 1'b0;
                    r_st   <= R_DATA;
                end
                R_DATA: if (r_done) begin
                    rd_ptr  <= rr_next(rd_g);
                    rd_busy <= 1'b0;
                    r_st    <= R_IDLE;
                end
                default: r_st <= R_IDLE;
            endcase
        end
    end

    assign bus.m_axi_awvalid = aw_vld;
    assign bus.m_axi_awaddr  = aw_addr_q;
    assign bus.m_axi_awlen   = aw_len_q;
    assign w_last_beat = (w_cnt == aw_len_q);
    assign w_beat      = (w_st == W_DATA) && bus.m_axi_wvalid && bus.m_axi_wready;
    assign b_hs        = (w_st == W_RESP) && bus.m_axi_bvalid && bus.m_axi_bready;

    always_comb begin
        bus.s_awready    = '0;
        bus.s_wready     = '0;
        bus.s_bvalid     = '0;
        bus.m_axi_wvalid = 1'b0;
        bus.m_axi_wlast  = 1'b0;
        bus.m_axi_bready = 1'b0;
        bus.m_axi_wdata  = bus.s_wdata[int'(wr_g)*DATA_WIDTH +: DATA_WIDTH];
        bus.m_axi_wstrb  = bus.s_wstrb[int'(wr_g)*STRB_W +: STRB_W];
        if (w_st == W_IDLE && w_found && ap_rst_n) bus.s_awready[w_win] = 1'b1;
        if (w_st == W_DATA) begin
            bus.m_axi_wvalid   = bus.s_wvalid[wr_g];
            bus.m_axi_wlast    = w_last_beat;
            bus.s_wready[wr_g] = bus.m_axi_wready;
        end
        if (w_st == W_RESP) begin
            bus.s_bvalid[wr_g] = bus.m_axi_bvalid;
            bus.m_axi_bready   = bus.s_bready[wr_g];
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_st      <= W_IDLE;
            wr_ptr    <= '0;
            wr_g      <= '0;
            aw_addr_q <= '0;
            aw_len_q  <= '0;
            aw_vld    <= 1'b0;
            w_cnt     <= '0;
            wr_busy   <= 1'b0;
            wlast_err <= 1'b0;
        end else begin
            // Burst length is owned by awlen; client wlast is only cross-checked.
            if (w_beat && (bus.s_wlast[wr_g] != w_last_beat)) wlast_err <= 1'b1;
            case (w_st)
                W_IDLE: if (w_found) begin
                    wr_g      <= w_win;
                    aw_addr_q <= bus.s_awaddr[int'(w_win)*ADDR_WIDTH +: ADDR_WIDTH];
                    aw_len_q  <= bus.s_awlen[int'(w_win)*8 +: 8];
                    aw_vld    <= 1'b1;
                    wr_busy   <= 1'b1;
                    w_st      <= W_ADDR;
                end
                W_ADDR: if (bus.m_axi_awready) begin
                    aw_vld <= 1'b0;
                    w_cnt  <= '0;
                    w_st   <= W_DATA;
                end
                W_DATA: if (w_beat) begin
                    if (w_last_beat) begin
                        w_cnt <= '0;
                        w_st  <= W_RESP;
                    end else begin
                        w_cnt <= w_cnt + 8'd1;
                    end
                end
                W_RESP: if (b_hs) begin
                    wr_ptr  <= rr_next(wr_g);
                    wr_busy <= 1'b0;
                    w_st    <= W_IDLE;
                end
                default: w_st <= W_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_mem_port_arbiter.sv
// Directed bench for axi4_mem_port_arbiter: grants, round-robin order, backpressure,
// wlast mismatch, concurrent read/write and asynchronous reset.
module tb_axi4_mem_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic ap_clk, ap_rst_n;
    logic rd_busy, wr_busy, wlast_err;
    int   checks, errors;

    axi4_mem_port_arbiter_if #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    axi4_mem_port_arbiter #(.NUM_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus),
        .rd_busy  (rd_busy),
        .wr_busy  (wr_busy),
        .wlast_err(wlast_err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [31:0] ch_addr(input int ch);
        return 32'h800 * (ch + 1);
    endfunction

    // Full read burst: req mask presented for one cycle, exp_ch must win.
    task automatic rd_txn(input logic [3:0] req, input int exp_ch, input int len, input bit bp);
        logic [3:0]  oh;
        logic [31:0] d;
        bit          rr;
        int          b;
        oh = 4'b0001 << exp_ch;
        b  = 0;
        bus.s_rready = '0;
        for (int i = 0; i < N; i++) begin
            bus.s_araddr[i*AW +: AW] = ch_addr(i);
            bus.s_arlen[i*8 +: 8]    = 8'(len);
        end
        bus.s_arvalid = req;
        #1;
        chk("ar_grant", bus.s_arready, oh);
        cyc();
        bus.s_arvalid     = '0;
        bus.m_axi_arready = !bp;
        #1;
        chk("ar_addr", {bus.m_axi_arvalid, bus.m_axi_araddr}, {1'b1, ch_addr(exp_ch)});
        chk("ar_len", bus.m_axi_arlen, len);
        chk("rd_busy_on", rd_busy, 1);
        if (bp) begin
            cyc();
            bus.m_axi_arready = 1'b1;
            #1;
            chk("ar_hold", {bus.m_axi_arvalid, bus.m_axi_araddr}, {1'b1, ch_addr(exp_ch)});
        end
        cyc();
        for (int k = 0; k < 4 * (len + 1) + 4 && b <= len; k++) begin
            rr = bp ? (k % 2 == 0) : 1'b1;
            d  = 32'hD000_0000 | (exp_ch << 8) | b;
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = d;
            bus.m_axi_rlast  = (b == len);
            bus.s_rready     = rr ? 4'hF : 4'h0;
            #1;
            if (k == 0) chk("ar_drop", bus.m_axi_arvalid, 0);
            chk("r_valid", bus.s_rvalid, oh);
            chk("r_ready", bus.m_axi_rready, rr);
            chk("r_last", bus.s_rlast, (b == len) ? oh : 4'h0);
            chk("r_data", bus.s_rdata, d);
            if (rr) b++;
            cyc();
        end
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        #1;
        chk("r_beats", b, len + 1);
        chk("rd_busy_off", rd_busy, 0);
    endtask

    // Full write burst from ch; bad_wl puts client wlast on the first beat only.
    task automatic wr_txn(input int ch, input int len, input bit bad_wl);
        logic [3:0]  oh;
        logic [31:0] d;
        logic [3:0]  s;
        oh = 4'b0001 << ch;
        bus.s_awaddr[ch*AW +: AW] = ch_addr(ch) + 32'h4000;
        bus.s_awlen[ch*8 +: 8]    = 8'(len);
        bus.s_awvalid = oh;
        #1;
        chk("aw_grant", bus.s_awready, oh);
        cyc();
        bus.s_awvalid = '0;
        #1;
        chk("aw_addr", {bus.m_axi_awvalid, bus.m_axi_awaddr}, {1'b1, ch_addr(ch) + 32'h4000});
        chk("aw_len", bus.m_axi_awlen, len);
        cyc();
        for (int b = 0; b <= len; b++) begin
            d = 32'hC000_0000 | (ch << 8) | b;
            s = (b % 2 == 0) ? 4'hF : 4'h3;
            bus.s_wvalid = oh;
            bus.s_wdata[ch*DW +: DW] = d;
            bus.s_wstrb[ch*4 +: 4]   = s;
            bus.s_wlast[ch]          = bad_wl ? (b == 0) : (b == len);
            #1;
            chk("w_valid", bus.m_axi_wvalid, 1);
            chk("w_ready", bus.s_wready, oh);
            chk("w_data", {bus.m_axi_wstrb, bus.m_axi_wdata}, {s, d});
            chk("w_last", bus.m_axi_wlast, b == len);
            cyc();
        end
        bus.s_wvalid = '0;
        bus.s_wlast  = '0;
        bus.m_axi_bvalid = 1'b1;
        #1;
        chk("w_stall", bus.m_axi_wvalid, 0);
        chk("b_valid", bus.s_bvalid, oh);
        chk("b_ready", bus.m_axi_bready, 1);
        cyc();
        bus.m_axi_bvalid = 1'b0;
        #1;
        chk("wr_busy_off", wr_busy, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        ap_rst_n = 1'b0;
        bus.s_arvalid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_rready = '0;
        bus.s_awvalid = '0; bus.s_awaddr = '0; bus.s_awlen = '0;
        bus.s_wvalid = '0; bus.s_wlast = '0; bus.s_bready = 4'hF;
        bus.s_wdata = {N{32'hBAD0_BAD0}}; bus.s_wstrb = '0;
        bus.m_axi_arready = 1'b1; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0; bus.m_axi_rlast = 1'b0;
        bus.m_axi_awready = 1'b1; bus.m_axi_wready = 1'b1; bus.m_axi_bvalid = 1'b0;

        // reset state, with a request pending
        bus.s_arvalid = 4'b0001;
        cyc(); cyc();
        chk("rst_busy", {rd_busy, wr_busy, wlast_err}, 3'b000);
        chk("rst_valids", {bus.m_axi_arvalid, bus.m_axi_awvalid, bus.m_axi_rready, bus.m_axi_wvalid}, 4'h0);
        chk("rst_arready", bus.s_arready, 4'h0);
        bus.s_arvalid = '0;
        ap_rst_n = 1'b1;
        cyc();

        // reads: single client, then round-robin order
        rd_txn(4'b0010, 1, 3, 1'b0);   // ptr -> 2
        rd_txn(4'b0111, 2, 0, 1'b0);   // ptr 2 picks ch2 -> 3
        rd_txn(4'b1000, 3, 1, 1'b0);   // -> 0
        rd_txn(4'b0101, 0, 1, 1'b0);   // ptr 0: ch0 first -> 1
        rd_txn(4'b0101, 2, 1, 1'b0);   // ptr 1: ch2 before ch0 -> 3
        rd_txn(4'b0101, 0, 0, 1'b0);   // ptr 3 wraps to ch0 -> 1
        rd_txn(4'b0100, 2, 7, 1'b1);   // backpressure, ptr -> 3

        // writes: clean, then wlast mismatch
        wr_txn(0, 2, 1'b0);
        chk("wl_err_clean", wlast_err, 0);
        wr_txn(3, 1, 1'b1);
        chk("wl_err_set", wlast_err, 1);

        // concurrent read ch0 / write ch1, 16 beats each
        bus.s_araddr[0 +: AW] = 32'h800; bus.s_arlen[0 +: 8] = 8'd15;
        bus.s_awaddr[AW +: AW] = 32'h1000; bus.s_awlen[8 +: 8] = 8'd15;
        bus.s_arvalid = 4'b0001; bus.s_awvalid = 4'b0010;
        #1;
        chk("cc_ready", {bus.s_arready, bus.s_awready}, 8'h12);
        cyc();
        bus.s_arvalid = '0; bus.s_awvalid = '0;
        #1;
        chk("cc_addr", {bus.m_axi_arvalid, bus.m_axi_awvalid}, 2'b11);
        cyc();
        for (int b = 0; b < 16; b++) begin
            bus.m_axi_rvalid = 1'b1; bus.m_axi_rdata = 32'hAA00 | b; bus.m_axi_rlast = (b == 15);
            bus.s_rready = 4'hF;
            bus.s_wvalid = 4'b0010; bus.s_wdata[DW +: DW] = 32'h5500 | b;
            bus.s_wstrb[4 +: 4] = 4'hF; bus.s_wlast[1] = (b == 15);
            #1;
            chk("cc_busy", {rd_busy, wr_busy}, 2'b11);
            chk("cc_route", {bus.s_rvalid, bus.s_wready}, 8'h12);
            chk("cc_data", {bus.s_rdata, bus.m_axi_wdata}, {32'hAA00 | b, 32'h5500 | b});
            chk("cc_last", {bus.s_rlast[0], bus.m_axi_wlast}, {b == 15, b == 15});
            cyc();
        end
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
        bus.s_wvalid = '0; bus.s_wlast = '0;
        bus.m_axi_bvalid = 1'b1;
        #1;
        chk("cc_done", {rd_busy, wr_busy, bus.s_bvalid}, 6'b01_0010);
        cyc();
        bus.m_axi_bvalid = 1'b0;
        #1;
        chk("cc_wr_off", wr_busy, 0);
        chk("wl_err_sticky", wlast_err, 1);

        // reset mid R_DATA (rd ptr is 1, so ch2 wins here)
        bus.s_arlen[16 +: 8] = 8'd3;
        bus.s_arvalid = 4'b0100;
        cyc();
        bus.s_arvalid = '0;
        cyc();
        bus.m_axi_rvalid = 1'b1; bus.s_rready = 4'hF;
        #1;
        chk("pre_rst_rvalid", bus.s_rvalid, 4'b0100);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("rst_now", {bus.s_rvalid, bus.m_axi_rready, rd_busy, wlast_err}, 7'h0);
        bus.m_axi_rvalid = 1'b0;
        cyc();
        ap_rst_n = 1'b1;
        cyc();
        rd_txn(4'b0101, 0, 1, 1'b0);   // ptr back at 0

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
